// File: rtl/udp_tx_pkg.sv
// Shared definitions for the UDP AXI-Stream transmitter.
//   state_e         : transmitter FSM states (StCsum only used with UDP_AXIS_TX_CSUM_EN)
//   UDP_HDR_BYTES   : UDP header size added to the payload length field
//   MAX_BYTES_DEFAULT : default payload capacity
//   last_keep()     : tkeep of the final payload beat from the payload length mod 4
package udp_tx_pkg;

  localparam int unsigned UDP_HDR_BYTES     = 8;
  localparam int unsigned MAX_BYTES_DEFAULT = 64;

  typedef enum logic [2:0] {
    StIdle,
    StCsum,
    StHdr0,
    StHdr1,
    StPay
  } state_e;

  // len is the payload length modulo 4; a multiple of 4 fills the whole beat.
  function automatic logic [3:0] last_keep(input logic [1:0] len);
    logic [3:0] keep;
    case (len)
      2'd0:    keep = 4'hF;
      2'd1:    keep = 4'h8;
      2'd2:    keep = 4'hC;
      default: keep = 4'hE;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/udp_csum_acc.sv
// Ones'-complement checksum accumulator for the UDP transmitter.
//   clock      : clock
//   clear      : synchronous clear (highest priority)
//   seed_en    : load sum of the four 16-bit terms in seed_terms
//   seed_terms : {pseudo_sum, src_port, dst_port, udp_length}
//   add_en     : accumulate both 16-bit halves of add_word
//   add_word   : 32-bit payload word, already zero-padded
//   result     : final checksum (~sum, with 0x0000 sent as 0xFFFF)
module udp_csum_acc (
  input  logic        clock,
  input  logic        clear,
  input  logic        seed_en,
  input  logic [63:0] seed_terms,
  input  logic        add_en,
  input  logic [31:0] add_word,
  output logic [15:0] result
);

  logic [15:0] acc_q;

  // 17-bit add with the carry folded straight back in; cannot carry a second time.
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'b0, s[16]};
  endfunction

  always_ff @(posedge clock) begin
    if (clear) begin
      acc_q <= '0;
    end else if (seed_en) begin
      acc_q <= oc_add(oc_add(seed_terms[63:48], seed_terms[47:32]),
                      oc_add(seed_terms[31:16], seed_terms[15:0]));
    end else if (add_en) begin
      acc_q <= oc_add(oc_add(acc_q, add_word[31:16]), add_word[15:0]);
    end
  end

  // A zero checksum means "not computed" in UDP, so an all-ones sum goes out as 0xFFFF.
  assign result = (acc_q == 16'hFFFF) ? 16'hFFFF : ~acc_q;

endmodule

// File: rtl/udp_axis_tx.sv
// UDP record to 32-bit AXI-Stream serialiser: two header beats, then payload beats.
//   clock, reset        : clock, synchronous active-high reset
//   in_valid/in_ready   : record handshake
//   in_bits_*           : payload (byte i at data[511-8i -: 8]), length, ports, checksum,
//                         pseudo-header sum
//   m_axis_*            : AXI-Stream master; tuser[0] flags a clamped length
//   len_err             : one-cycle pulse after accepting a record longer than MAX_BYTES
// Build option: define UDP_AXIS_TX_CSUM_EN to compute the UDP checksum in hardware
// (CSUM state) instead of passing in_bits_checksum through.
module udp_axis_tx
  import udp_tx_pkg::*;
#(
  parameter int unsigned MAX_BYTES = MAX_BYTES_DEFAULT,
  parameter logic [3:0]  TID       = 4'h0,
  parameter logic [3:0]  TDEST     = 4'h0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*MAX_BYTES-1:0] in_bits_data,
  input  logic [15:0]            in_bits_len,
  input  logic [15:0]            in_bits_src_port,
  input  logic [15:0]            in_bits_dst_port,
  input  logic [15:0]            in_bits_checksum,
  input  logic [15:0]            in_bits_pseudo_sum,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [31:0]            m_axis_tdata,
  output logic [3:0]             m_axis_tkeep,
  output logic [3:0]             m_axis_tstrb,
  output logic                   m_axis_tlast,
  output logic [3:0]             m_axis_tid,
  output logic [3:0]             m_axis_tdest,
  output logic [3:0]             m_axis_tuser,
  output logic                   len_err
);

  localparam int unsigned DataW = 8 * MAX_BYTES;
  localparam int unsigned LenW  = $clog2(MAX_BYTES + 1);
  localparam int unsigned Words = (MAX_BYTES + 3) / 4;

  state_e            state_q;
  logic [DataW-1:0]  data_q;
  logic [LenW-1:0]   eff_len_q;
  logic [4:0]        nbeats_q;
  logic [4:0]        beat_q;
  logic              in_ready_q, len_err_q;
  logic              tvalid_q, tlast_q;
  logic [31:0]       tdata_q;
  logic [3:0]        tkeep_q, tuser_q;

  logic              in_fire, clamp_in;
  logic [LenW-1:0]   eff_len_in;
  logic [LenW:0]     len_p3;
  logic [4:0]        nbeats_in;
  logic [15:0]       udp_len, hdr_chk;

  assign in_fire    = in_valid && in_ready_q;
  assign clamp_in   = in_bits_len > 16'(MAX_BYTES);
  assign eff_len_in = clamp_in ? LenW'(MAX_BYTES) : in_bits_len[LenW-1:0];
  assign len_p3     = {1'b0, eff_len_in} + (LenW+1)'(3);
  assign nbeats_in  = 5'(len_p3 >> 2);
  assign udp_len    = 16'(eff_len_q) + 16'(UDP_HDR_BYTES);

  // Payload word selection: the checksum pass walks beat_q, the output path looks one
  // beat ahead so the next beat can be registered on the current handshake.
  logic [4:0]  word_idx;
  logic        word_last;
  logic [3:0]  word_keep;
  logic [31:0] word_raw, word_data;

  always_comb begin
    case (state_q)
      StHdr1:  word_idx = '0;
      StPay:   word_idx = beat_q + 5'd1;
      default: word_idx = beat_q;
    endcase
    word_last = (word_idx == nbeats_q - 5'd1);
    word_keep = word_last ? last_keep(eff_len_q[1:0]) : 4'hF;
    word_raw  = '0;
    if (int'(word_idx) < Words) word_raw = data_q[DataW-1-32*int'(word_idx) -: 32];
    word_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (word_keep[3-i]) word_data[31-8*i -: 8] = word_raw[31-8*i -: 8];
    end
  end

`ifdef UDP_AXIS_TX_CSUM_EN
  logic unused_checksum;
  assign unused_checksum = ^in_bits_checksum;

  udp_csum_acc u_csum (
    .clock      (clock),
    .clear      (reset),
    .seed_en    (in_fire),
    .seed_terms ({in_bits_pseudo_sum, in_bits_src_port, in_bits_dst_port,
                  16'(eff_len_in) + 16'(UDP_HDR_BYTES)}),
    .add_en     (state_q == StCsum),
    .add_word   (word_data),
    .result     (hdr_chk)
  );
`else
  logic        unused_pseudo;
  logic [15:0] chk_q;
  assign unused_pseudo = ^in_bits_pseudo_sum;

  always_ff @(posedge clock) begin
    if (in_fire) chk_q <= in_bits_checksum;
  end
  assign hdr_chk = chk_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      data_q     <= '0;
      eff_len_q  <= '0;
      nbeats_q   <= '0;
      beat_q     <= '0;
      in_ready_q <= 1'b1;
      len_err_q  <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tlast_q    <= 1'b0;
      tuser_q    <= '0;
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (in_fire) begin
            data_q     <= in_bits_data;
            eff_len_q  <= eff_len_in;
            nbeats_q   <= nbeats_in;
            beat_q     <= '0;
            in_ready_q <= 1'b0;
            len_err_q  <= clamp_in;
            // HDR0 beat is staged now; tuser stays fixed for the whole frame.
            tdata_q    <= {in_bits_src_port, in_bits_dst_port};
            tkeep_q    <= 4'hF;
            tlast_q    <= 1'b0;
            tuser_q    <= {3'b000, clamp_in};
`ifdef UDP_AXIS_TX_CSUM_EN
            state_q    <= (nbeats_in != '0) ? StCsum : StHdr0;
            tvalid_q   <= (nbeats_in == '0);
`else
            state_q    <= StHdr0;
            tvalid_q   <= 1'b1;
`endif
          end
        end
        StCsum: begin
          if (beat_q == nbeats_q - 5'd1) begin
            beat_q   <= '0;
            state_q  <= StHdr0;
            tvalid_q <= 1'b1;
          end else begin
            beat_q <= beat_q + 5'd1;
          end
        end
        StHdr0: begin
          if (m_axis_tready) begin
            state_q <= StHdr1;
            tdata_q <= {udp_len, hdr_chk};
            tlast_q <= (eff_len_q == '0);
          end
        end
        StHdr1, StPay: begin
          if (m_axis_tready) begin
            if (tlast_q) begin
              state_q    <= StIdle;
              in_ready_q <= 1'b1;
              tvalid_q   <= 1'b0;
              tdata_q    <= '0;
              tkeep_q    <= '0;
              tlast_q    <= 1'b0;
              tuser_q    <= '0;
            end else begin
              state_q <= StPay;
              beat_q  <= (state_q == StHdr1) ? 5'd0 : beat_q + 5'd1;
              tdata_q <= word_data;
              tkeep_q <= word_keep;
              tlast_q <= word_last;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign len_err       = len_err_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tstrb  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tid    = TID;
  assign m_axis_tdest  = TDEST;

endmodule

// File: tb/tb_udp_axis_tx.sv
`timescale 1ns/1ps
module tb_udp_axis_tx;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] in_bits_data = '0;
  logic [15:0]  in_bits_len = '0, in_bits_src_port = '0, in_bits_dst_port = '0;
  logic [15:0]  in_bits_checksum = '0, in_bits_pseudo_sum = '0;
  logic         m_axis_tvalid, m_axis_tlast, len_err;
  logic         m_axis_tready = 1'b1;
  logic [31:0]  m_axis_tdata;
  logic [3:0]   m_axis_tkeep, m_axis_tstrb, m_axis_tid, m_axis_tdest, m_axis_tuser;

  udp_axis_tx dut (
    .clock              (clock),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_bits_data       (in_bits_data),
    .in_bits_len        (in_bits_len),
    .in_bits_src_port   (in_bits_src_port),
    .in_bits_dst_port   (in_bits_dst_port),
    .in_bits_checksum   (in_bits_checksum),
    .in_bits_pseudo_sum (in_bits_pseudo_sum),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tkeep       (m_axis_tkeep),
    .m_axis_tstrb       (m_axis_tstrb),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tid         (m_axis_tid),
    .m_axis_tdest       (m_axis_tdest),
    .m_axis_tuser       (m_axis_tuser),
    .len_err            (len_err)
  );

  always #5 clock = ~clock;

`ifdef UDP_AXIS_TX_CSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [3:0]  user;
  } beat_t;

  beat_t      exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         stall_holds = 0;
  bit         bp_en = 1'b0;
  int         bp_idx = 0;
  logic [5:0] bp_pat = 6'b101001;  // tready 1,0,0,1,0,1 from bit 0 upward

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (bp_en) begin
      m_axis_tready = bp_pat[bp_idx % 6];
      bp_idx++;
    end else begin
      m_axis_tready = 1'b1;
    end
  end

  // Scoreboard monitor: pops one expected beat per handshake, checks holds during stalls.
  bit    stall_q = 1'b0;
  beat_t held;
  always @(negedge clock) begin
    beat_t e;
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        stall_holds++;
        chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
        chk("hold_data", m_axis_tdata, held.data);
        chk("hold_ctl", 32'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}),
            32'({held.keep, held.last, held.user}));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat got=%0h exp=none", m_axis_tdata);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tdata", m_axis_tdata, e.data);
          chk("tkeep", 32'(m_axis_tkeep), 32'(e.keep));
          chk("tstrb", 32'(m_axis_tstrb), 32'(e.keep));
          chk("tlast", 32'(m_axis_tlast), 32'(e.last));
          chk("tuser", 32'(m_axis_tuser), 32'(e.user));
          chk("tid_tdest", 32'({m_axis_tid, m_axis_tdest}), 32'd0);
        end
      end
      stall_q = m_axis_tvalid && !m_axis_tready;
      held    = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
    end
  end

  function automatic logic [511:0] make_data(input int n);
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[511-8*i -: 8] = (i < n) ? 8'(i + 1) : 8'hA5;
    return d;
  endfunction

`ifdef UDP_AXIS_TX_CSUM_EN
  function automatic logic [15:0] model_csum(input logic [15:0] src, dst, psum, input int eff,
                                             input logic [511:0] d);
    int unsigned s;
    logic [7:0]  hi, lo;
    s = 32'(psum) + 32'(src) + 32'(dst) + 32'(eff) + 32'd8;
    for (int b = 0; b < eff; b += 2) begin
      hi = d[511-8*b -: 8];
      lo = (b + 1 < eff) ? d[511-8*(b+1) -: 8] : 8'h00;
      s += 32'({hi, lo});
    end
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return (s == 32'hFFFF) ? 16'hFFFF : 16'(~s);
  endfunction
`endif

  task automatic push_frame(input logic [15:0] src, dst, len, chk_in, psum,
                            input logic [511:0] d);
    int          eff, nb;
    logic [3:0]  u, kp;
    logic [15:0] c;
    logic [31:0] w;
    eff = (len > 16'd64) ? 64 : int'(len);
    nb  = (eff + 3) / 4;
    u   = {3'b000, len > 16'd64};
    c   = chk_in;
`ifdef UDP_AXIS_TX_CSUM_EN
    c   = model_csum(src, dst, psum, eff, d);
`endif
    exp_q.push_back({src, dst, 4'hF, 1'b0, u});
    exp_q.push_back({16'(eff + 8), c, 4'hF, eff == 0, u});
    for (int k = 0; k < nb; k++) begin
      w  = '0;
      kp = '0;
      for (int j = 0; j < 4; j++) begin
        if (4 * k + j < eff) begin
          w[31-8*j -: 8] = d[511-8*(4*k+j) -: 8];
          kp[3-j] = 1'b1;
        end
      end
      exp_q.push_back({w, kp, k == nb - 1, u});
    end
  endtask

  task automatic push_basic();
    exp_q.push_back({32'h12345678, 4'hF, 1'b0, 4'h0});
`ifdef UDP_AXIS_TX_CSUM_EN
    exp_q.push_back({32'h000E8E39, 4'hF, 1'b0, 4'h0});
`else
    exp_q.push_back({32'h000EABCD, 4'hF, 1'b0, 4'h0});
`endif
    exp_q.push_back({32'h01020304, 4'hF, 1'b0, 4'h0});
    exp_q.push_back({32'h05060000, 4'hC, 1'b1, 4'h0});
  endtask

  // Returns at the negedge where the HDR0 beat is first presented.
  task automatic send(input logic [15:0] src, dst, len, chk_in, psum,
                      input logic [511:0] d, input bit push_model);
    int n, eff, lat;
    eff = (len > 16'd64) ? 64 : int'(len);
    lat = CsumEn ? (eff + 3) / 4 : 0;
    @(posedge clock); #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid           = 1'b1;
    in_bits_src_port   = src;
    in_bits_dst_port   = dst;
    in_bits_len        = len;
    in_bits_checksum   = chk_in;
    in_bits_pseudo_sum = psum;
    in_bits_data       = d;
    if (push_model) push_frame(src, dst, len, chk_in, psum, d);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("len_err", 32'(len_err), 32'(len > 16'd64));
    chk("busy_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < lat; i++) begin
      chk("csum_latency_idle", 32'(m_axis_tvalid), 32'd0);
      @(negedge clock);
    end
    chk("first_valid", 32'(m_axis_tvalid), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s_drain got=%0d beats left exp=0", tag, exp_q.size());
      exp_q.delete();
    end
    @(negedge clock);
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_idle_valid"}, 32'(m_axis_tvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_ctl", 32'({m_axis_tkeep, m_axis_tstrb, m_axis_tlast, m_axis_tuser}), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);

    // Basic frame (also the checksum case with the macro: pseudo_sum 0).
    push_basic();
    send(16'h1234, 16'h5678, 16'd6, 16'hABCD, 16'h0000, make_data(6), 1'b0);
    wait_done("basic");

    // Zero-length payload.
    send(16'h4321, 16'h8765, 16'd0, 16'h5A5A, 16'h1111, make_data(0), 1'b1);
    wait_done("zero_len");

    // Backpressure on the basic frame.
    bp_en = 1'b1;
    push_basic();
    send(16'h1234, 16'h5678, 16'd6, 16'hABCD, 16'h0000, make_data(6), 1'b0);
    wait_done("backpressure");
    checks++;
    assert (stall_holds > 0) else begin
      errors++;
      $error("FAIL stall_seen got=%0d exp=>0", stall_holds);
    end

    // Odd length under backpressure: last keep 1110.
    send(16'h0400, 16'h0035, 16'd7, 16'hFEDC, 16'h2222, make_data(7), 1'b1);
    wait_done("len7");
    bp_en = 1'b0;

    // Over-length: clamped to 64, len_err pulse, tuser[0] on every beat.
    send(16'hC000, 16'h0044, 16'd70, 16'h0F0F, 16'h3333, make_data(70), 1'b1);
    wait_done("over_len");

    // Reset while PAY beat 1 is on the bus.
    send(16'h1111, 16'h2222, 16'd12, 16'h3333, 16'h0000, make_data(12), 1'b1);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    exp_q.delete();
    @(negedge clock);
    chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midrst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1 reset = 1'b0;

    // Clean frame after the abort, with backpressure: last keep 1000.
    bp_en = 1'b1;
    send(16'hBEEF, 16'hCAFE, 16'd5, 16'h1234, 16'h4444, make_data(5), 1'b1);
    wait_done("post_reset");
    bp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_axis_tx.md
Name: udp_axis_tx

Overview:
- Transmit-side counterpart of the AXI-Stream packet analyser.
- Accepts one parsed UDP record per handshake: payload up to 64 bytes, length, and header fields.
- Serialises it as a 32-bit AXI-Stream frame: UDP header beats first, then payload beats, with tkeep/tlast framing.
- Feeds the MAC-side AXI-Stream path.

Parameters:
- MAX_BYTES, 64, payload capacity in bytes; `in_bits_data` width is 8*MAX_BYTES.
- TID, 4'h0, constant driven on `m_axis_tid`.
- TDEST, 4'h0, constant driven on `m_axis_tdest`.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  record valid
- in_ready  out  1  record accepted when `in_valid && in_ready`
- in_bits_data  in  512  payload; byte i = `data[511-8i -: 8]`
- in_bits_len  in  16  payload length in bytes
- in_bits_src_port  in  16  UDP source port
- in_bits_dst_port  in  16  UDP destination port
- in_bits_checksum  in  16  UDP checksum (used only without the macro)
- in_bits_pseudo_sum  in  16  IP pseudo-header ones'-complement sum (used only with the macro)
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tdata  out  32  beat data, first byte in [31:24]
- m_axis_tkeep  out  4  byte enables; tkeep[3] covers [31:24]
- m_axis_tstrb  out  4  equals tkeep
- m_axis_tlast  out  1  last beat of frame
- m_axis_tid  out  4  TID
- m_axis_tdest  out  4  TDEST
- m_axis_tuser  out  4  bit0 = length clamped; bits [3:1] = 0
- len_err  out  1  one-cycle pulse on accept when `in_bits_len > MAX_BYTES`

Behaviour:
- **Reset values:** `in_ready`=1 and all other outputs 0 in the cycle after reset; FSM in IDLE.
- **Reset mid-frame:** aborts the frame. tvalid drops the next cycle with no tlast; the latched record is discarded.
- **States:** IDLE, [CSUM], HDR0, HDR1, PAY.
- **IDLE:** `in_ready`=1. On accept:
  - latch all inputs;
  - eff_len = min(len, MAX_BYTES); set the clamp flag if len > MAX_BYTES;
  - go to HDR0 (or CSUM with the macro). First tvalid is one cycle after accept.
- **HDR0:**
  - tdata = {src_port, dst_port}, tkeep=4'hF, tlast=0.
- **HDR1:**
  - tdata = {eff_len+8, checksum}, tkeep=4'hF.
  - tlast=1 iff eff_len==0, then return to IDLE.
- **PAY:** beat k (from 0) = `data[511-32k -: 32]`; beats = ceil(eff_len/4).
  - Final beat: tlast=1; tkeep from eff_len%4: 0→1111, 1→1000, 2→1100, 3→1110.
  - Bytes outside tkeep are driven 0.
- **Handshake:**
  - A state advances only when `tvalid && tready`.
  - While tready=0, tdata/tkeep/tlast/tuser are held stable.
  - No bubbles between beats of a frame.
  - After the tlast handshake: IDLE, in_ready=1 the next cycle. Minimum one idle cycle between frames.
- **Beat counter:** 5 bits, wraps nothing; frame length bounded by MAX_BYTES.
- **tuser[0]:** carries the clamp flag on every beat of the frame.

Optional Feature:
- **Macro:** `UDP_AXIS_TX_CSUM_EN`.
- **Defined:**
  - CSUM state runs after accept, one 32-bit payload word per cycle, for ceil(eff_len/4) cycles; zero cycles if eff_len=0.
  - Accumulator: 17-bit ones'-complement, end-around carry folded each add.
  - Accumulator seeded with pseudo_sum + src + dst + (eff_len+8); payload padded with zero bytes.
  - Checksum = ~sum; a result of 0x0000 is sent as 0xFFFF.
  - `in_bits_checksum` is ignored.
  - First tvalid at accept + 1 + ceil(eff_len/4).
- **Undefined:**
  - CSUM state and `in_bits_pseudo_sum` unused.
  - `in_bits_checksum` is passed through unchanged.

Decomposition:
- Package `udp_tx_pkg`: state enum; UDP_HDR_BYTES=8; MAX_BYTES_DEFAULT=64; function `last_keep(len)` returning 4-bit tkeep.
- Sub-module `udp_csum_acc` (ones'-complement accumulator: clear/seed/add32/result), instantiated only under the macro.

Test Plan:
- **Basic frame:** src 0x1234, dst 0x5678, len 6, chk 0xABCD, bytes 01..06, tready=1. Beats:
  - 0x12345678 keep F;
  - 0x000EABCD keep F;
  - 0x01020304 keep F;
  - 0x05060000 keep C, tlast.
- **Zero length:** len 0 → two beats; second is 0x0008xxxx with tlast; in_ready high the cycle after.
- **Backpressure:** same as the basic frame with tready toggled 1,0,0,1,0,1… → identical beat sequence; tdata held stable through every stall.
- **Over-length:** len 70 → len_err pulse; 2+16 beats, last keep F; HDR1 length field 0x0048; tuser[0]=1 on all beats.
- **Reset mid-frame:** reset asserted during PAY beat 1 → tvalid 0 the next cycle, in_ready 1; the following frame is emitted cleanly.
- **Checksum (`UDP_AXIS_TX_CSUM_EN`):** basic-frame inputs with pseudo_sum 0 → HDR1 = 0x000E8E39; first tvalid 3 cycles after accept.
